// File: rtl/sdram_share_arbiter.sv
// rtl/sdram_share_arbiter.sv - shares the toggle-handshake SDRAM port between the CPU RAM bus and FDC DMA
module sdram_share_arbiter #(
    parameter int              AW         = 24,
    parameter logic [AW-1:0]   FDC_BASE   = 'h010000,
    parameter int              CPU_STREAK = 4,
    parameter int              TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_cs,
    input  logic          cpu_oe,
    input  logic          cpu_we,
    input  logic [15:0]   cpu_ad,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    input  logic          fdc_req,
    input  logic          fdc_we,
    input  logic [19:0]   fdc_a,
    input  logic [7:0]    fdc_d,
    output logic [7:0]    fdc_q,
    output logic          fdc_ack,
    output logic          sdram_req,
    input  logic          sdram_ack,
    output logic [AW-1:0] sdram_a,
    output logic [1:0]    sdram_ds,
    output logic          sdram_we,
    output logic [15:0]   sdram_d,
    input  logic [15:0]   sdram_q,
    output logic          busy,
    output logic          err
);

    localparam int SW = $clog2(CPU_STREAK + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {SYNC, IDLE, WAIT_CPU, WAIT_FDC} state_t;

    state_t        state;
    state_t        state_nxt;

    logic          rd_now;
    logic          wr_now;
    logic          rd_old;
    logic          wr_old;
    logic [15:0]   ad_old;
    logic          cpu_det;

    logic          cpu_pend;
    logic          cpu_we_r;
    logic [15:0]   cpu_ad_r;
    logic [7:0]    cpu_d_r;

    logic          fdc_pend;
    logic          fdc_we_r;
    logic [19:0]   fdc_a_r;
    logic [7:0]    fdc_d_r;
    logic          fdc_take;

    logic [SW-1:0] streak;
    logic [CW-1:0] cnt;
    logic          cur_b0;

    logic          in_step;
    logic          grant_cpu;
    logic          grant_fdc;
    logic          done;
    logic          expire;

    assign rd_now   = cpu_cs & cpu_oe;
    assign wr_now   = cpu_cs & cpu_we;
    // A new CPU access is an enable rising edge, or a read whose address moved while oe stayed high.
    assign cpu_det  = (rd_now & ~rd_old) | (wr_now & ~wr_old) | (rd_now & (cpu_ad != ad_old));
    // A second FDC strobe is dropped while one is queued or being serviced.
    assign fdc_take = fdc_req & ~fdc_pend & (state != WAIT_FDC);
    assign in_step  = (sdram_ack == sdram_req);
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, completion and timeout decisions.
    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_fdc = 1'b0;
        done      = 1'b0;
        expire    = 1'b0;
        case (state)
            SYNC: begin
                if (in_step) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (fdc_pend && (streak >= SW'(CPU_STREAK))) begin
                    grant_fdc = 1'b1;
                    state_nxt = WAIT_FDC;
                end else if (cpu_pend) begin
                    grant_cpu = 1'b1;
                    state_nxt = WAIT_CPU;
                end else if (fdc_pend) begin
                    grant_fdc = 1'b1;
                    state_nxt = WAIT_FDC;
                end
            end
            WAIT_CPU, WAIT_FDC: begin
                if (in_step) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    expire    = 1'b1;
                    state_nxt = SYNC;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    // Request capture, issue onto the SDRAM port, and completion bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_old    <= 1'b0;
            wr_old    <= 1'b0;
            ad_old    <= '0;
            cpu_pend  <= 1'b0;
            cpu_we_r  <= 1'b0;
            cpu_ad_r  <= '0;
            cpu_d_r   <= '0;
            fdc_pend  <= 1'b0;
            fdc_we_r  <= 1'b0;
            fdc_a_r   <= '0;
            fdc_d_r   <= '0;
            streak    <= '0;
            cnt       <= '0;
            cur_b0    <= 1'b0;
            sdram_req <= 1'b0;
            sdram_a   <= '0;
            sdram_ds  <= '0;
            sdram_we  <= 1'b0;
            sdram_d   <= '0;
            cpu_q     <= '0;
            fdc_q     <= '0;
            fdc_ack   <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_old  <= rd_now;
            wr_old  <= wr_now;
            ad_old  <= cpu_ad;
            fdc_ack <= 1'b0;

            // Grant clears the flag, but a detection in the same cycle re-arms it with fresh fields.
            if (grant_cpu) begin
                cpu_pend <= 1'b0;
            end
            if (cpu_det) begin
                cpu_pend <= 1'b1;
                cpu_ad_r <= cpu_ad;
                cpu_d_r  <= cpu_d;
                cpu_we_r <= wr_now;
            end

            if (grant_fdc) begin
                fdc_pend <= 1'b0;
            end
            if (fdc_take) begin
                fdc_pend <= 1'b1;
                fdc_we_r <= fdc_we;
                fdc_a_r  <= fdc_a;
                fdc_d_r  <= fdc_d;
            end

            if (grant_cpu || grant_fdc) begin
                sdram_req <= ~sdram_req;
                cnt       <= '0;
            end else if ((state == WAIT_CPU || state == WAIT_FDC) && !done && !expire) begin
                cnt <= cnt + CW'(1);
            end

            if (grant_cpu) begin
                sdram_a  <= {{(AW-15){1'b0}}, cpu_ad_r[15:1]};
                sdram_ds <= cpu_we_r ? (cpu_ad_r[0] ? 2'b10 : 2'b01) : 2'b11;
                sdram_we <= cpu_we_r;
                sdram_d  <= {cpu_d_r, cpu_d_r};
                cur_b0   <= cpu_ad_r[0];
                if (fdc_pend && (streak < SW'(CPU_STREAK))) begin
                    streak <= streak + SW'(1);
                end
            end

            if (grant_fdc) begin
                sdram_a  <= FDC_BASE + {{(AW-19){1'b0}}, fdc_a_r[19:1]};
                sdram_ds <= fdc_we_r ? (fdc_a_r[0] ? 2'b10 : 2'b01) : 2'b11;
                sdram_we <= fdc_we_r;
                sdram_d  <= {fdc_d_r, fdc_d_r};
                cur_b0   <= fdc_a_r[0];
                streak   <= '0;
            end

            if (done) begin
                if (!sdram_we) begin
                    if (state == WAIT_CPU) begin
                        cpu_q <= cur_b0 ? sdram_q[15:8] : sdram_q[7:0];
                    end else begin
                        fdc_q <= cur_b0 ? sdram_q[15:8] : sdram_q[7:0];
                    end
                end
                if (state == WAIT_FDC) begin
                    fdc_ack <= 1'b1;
                end
            end

            // Abandoned access: flag it, and still release the FDC so its DMA does not stall.
            if (expire) begin
                err <= 1'b1;
                if (state == WAIT_FDC) begin
                    fdc_ack <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_share_arbiter.sv
// tb/tb_sdram_share_arbiter.sv - self-checking bench for sdram_share_arbiter
module tb_sdram_share_arbiter;

    localparam int          AW       = 24;
    localparam logic [23:0] FDC_BASE = 24'h010000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_cs = 1'b0;
    logic        cpu_oe = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_ad = '0;
    logic [7:0]  cpu_d = '0;
    logic [7:0]  cpu_q;
    logic        fdc_req = 1'b0;
    logic        fdc_we = 1'b0;
    logic [19:0] fdc_a = '0;
    logic [7:0]  fdc_d = '0;
    logic [7:0]  fdc_q;
    logic        fdc_ack;
    logic        sdram_req;
    logic        sdram_ack;
    logic [23:0] sdram_a;
    logic [1:0]  sdram_ds;
    logic        sdram_we;
    logic [15:0] sdram_d;
    logic [15:0] sdram_q;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;

    sdram_share_arbiter #(.AW(AW), .FDC_BASE(FDC_BASE), .CPU_STREAK(4), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_q(cpu_q),
        .fdc_req(fdc_req), .fdc_we(fdc_we), .fdc_a(fdc_a), .fdc_d(fdc_d), .fdc_q(fdc_q), .fdc_ack(fdc_ack),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_a(sdram_a), .sdram_ds(sdram_ds),
        .sdram_we(sdram_we), .sdram_d(sdram_d), .sdram_q(sdram_q),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // SDRAM port model: word memory with byte lanes, random ack latency, optional forced read data.
    logic        ack_en = 1'b1;
    int          lat_max = 3;
    logic        q_force_en = 1'b0;
    logic [15:0] q_force = '0;
    int          flip_req = 0;
    logic [15:0] mem [int];

    initial begin : sdram_model
        int          left;
        int          flip_done;
        int          w;
        logic [15:0] word;
        sdram_ack = 1'b0;
        sdram_q   = '0;
        left      = 0;
        flip_done = 0;
        forever begin
            @(posedge clk);
            #2;
            if (flip_req != flip_done) begin
                sdram_ack = ~sdram_ack;
                flip_done++;
            end else if (ack_en && (sdram_req != sdram_ack)) begin
                if (left > 0) begin
                    left--;
                end else begin
                    w = int'(sdram_a);
                    word = mem.exists(w) ? mem[w] : 16'h0000;
                    if (sdram_we) begin
                        if (sdram_ds[0]) word[7:0] = sdram_d[7:0];
                        if (sdram_ds[1]) word[15:8] = sdram_d[15:8];
                        mem[w] = word;
                    end else begin
                        sdram_q = q_force_en ? q_force : word;
                    end
                    sdram_ack = sdram_req;
                    left = $urandom_range(lat_max, 0);
                end
            end
        end
    end

    // Log of every request toggle with the command fields, plus fdc_ack pulses.
    typedef struct {
        logic [23:0] a;
        logic [1:0]  ds;
        logic        we;
        logic [15:0] d;
    } acc_t;

    acc_t       log_q [$];
    int         fdc_ack_cnt = 0;
    logic [7:0] fdc_ack_q = '0;

    initial begin : monitor
        logic last_req;
        acc_t e;
        last_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && (sdram_req !== last_req)) begin
                e.a = sdram_a; e.ds = sdram_ds; e.we = sdram_we; e.d = sdram_d;
                log_q.push_back(e);
            end
            last_req = sdram_req;
            if (fdc_ack === 1'b1) begin
                fdc_ack_cnt++;
                fdc_ack_q = fdc_q;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    logic [7:0] ref_mem [int];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    function automatic acc_t entry(input int i);
        acc_t e;
        e.a = 'x; e.ds = 'x; e.we = 1'bx; e.d = 'x;
        if (i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    task automatic wait_log(input int n, input int budget, output bit ok);
        int c = 0;
        while (log_q.size() < n && c < budget) begin tick(1); c++; end
        ok = (log_q.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int c = 0;
        while (busy !== 1'b0 && c < budget) begin tick(1); c++; end
        ok = (busy === 1'b0);
    endtask

    task automatic wait_fdc_ack(input int n, input int budget, output bit ok);
        int c = 0;
        while (fdc_ack_cnt < n && c < budget) begin tick(1); c++; end
        ok = (fdc_ack_cnt >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", sdram_req); end
        checks++; if (cpu_q !== 8'h00) begin failures++; $display("FAIL reset_cpu_q: got %h expected 00", cpu_q); end
        checks++; if (fdc_q !== 8'h00) begin failures++; $display("FAIL reset_fdc_q: got %h expected 00", fdc_q); end
        checks++; if (fdc_ack !== 1'b0) begin failures++; $display("FAIL reset_fdc_ack: got %b expected 0", fdc_ack); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy_sync: got %b expected 1", busy); end
        reset = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_to_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_cpu_write();
        int   n0 = log_q.size();
        acc_t e;
        cpu_ad = 16'h1235; cpu_d = 8'hA5; cpu_cs = 1'b1; cpu_we = 1'b1;
        tick(20);
        e = entry(n0);
        checks++; if (log_q.size() - n0 != 1) begin failures++; $display("FAIL cpu_wr_toggles: got %0d expected 1", log_q.size() - n0); end
        checks++; if (e.a !== 24'h00091A) begin failures++; $display("FAIL cpu_wr_addr: got %h expected 00091a", e.a); end
        checks++; if (e.ds !== 2'b10) begin failures++; $display("FAIL cpu_wr_ds: got %b expected 10", e.ds); end
        checks++; if (e.we !== 1'b1) begin failures++; $display("FAIL cpu_wr_we: got %b expected 1", e.we); end
        checks++; if (e.d !== 16'hA5A5) begin failures++; $display("FAIL cpu_wr_data: got %h expected a5a5", e.d); end
        cpu_cs = 1'b0; cpu_we = 1'b0;
        tick(2);
    endtask

    task automatic test_cpu_read();
        int   n0 = log_q.size();
        acc_t e0, e1;
        q_force_en = 1'b1; q_force = 16'h7F3C;
        cpu_ad = 16'h0400; cpu_cs = 1'b1; cpu_oe = 1'b1;
        tick(10);
        checks++; if (cpu_q !== 8'h3C) begin failures++; $display("FAIL cpu_rd_lo: got %h expected 3c", cpu_q); end
        checks++; if (log_q.size() - n0 != 1) begin failures++; $display("FAIL cpu_rd_first_count: got %0d expected 1", log_q.size() - n0); end
        cpu_ad = 16'h0401;
        tick(10);
        checks++; if (cpu_q !== 8'h7F) begin failures++; $display("FAIL cpu_rd_hi: got %h expected 7f", cpu_q); end
        checks++; if (log_q.size() - n0 != 2) begin failures++; $display("FAIL cpu_rd_count: got %0d expected 2", log_q.size() - n0); end
        e0 = entry(n0); e1 = entry(n0 + 1);
        checks++; if (e0.a !== 24'h000200 || e1.a !== 24'h000200) begin failures++; $display("FAIL cpu_rd_addr: got %h/%h expected 000200", e0.a, e1.a); end
        checks++; if (e0.ds !== 2'b11 || e1.ds !== 2'b11 || e0.we !== 1'b0 || e1.we !== 1'b0) begin failures++; $display("FAIL cpu_rd_lanes: got ds %b/%b we %b/%b expected 11 and 0", e0.ds, e1.ds, e0.we, e1.we); end
        cpu_cs = 1'b0; cpu_oe = 1'b0; q_force_en = 1'b0;
        tick(2);
    endtask

    task automatic test_fdc_read();
        int   n0 = log_q.size();
        int   a0 = fdc_ack_cnt;
        bit   ok;
        acc_t e;
        q_force_en = 1'b1; q_force = 16'hBE00;
        fdc_a = 20'h00003; fdc_we = 1'b0; fdc_req = 1'b1;
        tick(1);
        fdc_req = 1'b0;
        checks++; if (log_q.size() != n0) begin failures++; $display("FAIL fdc_early_grant: got %0d toggles expected 0", log_q.size() - n0); end
        tick(1);
        checks++; if (log_q.size() != n0 + 1) begin failures++; $display("FAIL fdc_grant_latency: got %0d toggles expected 1", log_q.size() - n0); end
        e = entry(n0);
        checks++; if (e.a !== 24'h010001 || e.ds !== 2'b11 || e.we !== 1'b0) begin failures++; $display("FAIL fdc_rd_cmd: got a=%h ds=%b we=%b expected 010001 11 0", e.a, e.ds, e.we); end
        wait_fdc_ack(a0 + 1, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fdc_rd_ack_wait: got no ack expected ack within 50 cycles"); end
        checks++; if (fdc_ack_q !== 8'hBE) begin failures++; $display("FAIL fdc_rd_data: got %h expected be", fdc_ack_q); end
        tick(10);
        checks++; if (fdc_ack_cnt != a0 + 1) begin failures++; $display("FAIL fdc_ack_pulses: got %0d expected 1", fdc_ack_cnt - a0); end
        q_force_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        int   n0 = log_q.size();
        bit   ok;
        acc_t e0, e1;
        cpu_ad = 16'h0010; cpu_d = 8'h5A; cpu_cs = 1'b1; cpu_we = 1'b1;
        fdc_a = 20'h00004; fdc_d = 8'hC3; fdc_we = 1'b1; fdc_req = 1'b1;
        tick(1);
        fdc_req = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
        wait_log(n0 + 2, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL sim_wait: got %0d toggles expected 2", log_q.size() - n0); end
        e0 = entry(n0); e1 = entry(n0 + 1);
        checks++; if (e0.a !== 24'h000008 || e0.ds !== 2'b01 || e0.d !== 16'h5A5A) begin failures++; $display("FAIL sim_cpu_first: got a=%h ds=%b d=%h expected 000008 01 5a5a", e0.a, e0.ds, e0.d); end
        checks++; if (e1.a !== 24'h010002 || e1.ds !== 2'b01 || e1.d !== 16'hC3C3 || e1.we !== 1'b1) begin failures++; $display("FAIL sim_fdc_second: got a=%h ds=%b d=%h we=%b expected 010002 01 c3c3 1", e1.a, e1.ds, e1.d, e1.we); end
        wait_idle(50, ok);
        tick(2);
    endtask

    task automatic test_streak();
        int          idx0 = -1;
        int          i = 0;
        bit          ok = 1'b0;
        logic [15:0] ad = 16'h1000;
        acc_t        e;
        bit          want_fdc;
        lat_max = 2;
        cpu_we = 1'b0; cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_ad = ad;
        fdc_we = 1'b0; fdc_a = 20'h00010;
        while (i < 300) begin
            tick(1);
            i++;
            ad = ad + 16'd1;
            cpu_ad = ad;
            fdc_req = (i == 3);
            if (i == 4) idx0 = log_q.size();
            if (idx0 >= 0 && log_q.size() >= idx0 + 6) begin ok = 1'b1; break; end
        end
        cpu_cs = 1'b0; cpu_oe = 1'b0; fdc_req = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL streak_wait: got %0d grants expected 6", log_q.size() - idx0); end
        for (int k = 0; k < 6; k++) begin
            e = entry(idx0 + k);
            want_fdc = (k == 4);
            checks++;
            if (want_fdc && e.a !== 24'h010008) begin failures++; $display("FAIL streak_order_%0d: got a=%h expected fdc 010008", k, e.a); end
            else if (!want_fdc && !(e.a < 24'h008000)) begin failures++; $display("FAIL streak_order_%0d: got a=%h expected cpu address", k, e.a); end
        end
        wait_idle(50, ok);
        tick(5);
        lat_max = 3;
    endtask

    task automatic test_timeout();
        int         n0 = log_q.size();
        int         a0 = fdc_ack_cnt;
        int         cyc = 0;
        logic       err_mid = 1'bx;
        logic [7:0] fq0 = fdc_q;
        bit         ok;
        ack_en = 1'b0;
        fdc_a = 20'h00020; fdc_we = 1'b0; fdc_req = 1'b1;
        tick(1);
        fdc_req = 1'b0;
        wait_log(n0 + 1, 10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL to_grant: got no toggle expected one"); end
        while (fdc_ack_cnt == a0 && cyc < 400) begin
            tick(1);
            cyc++;
            if (cyc == 250) err_mid = err;
        end
        checks++; if (cyc < 254 || cyc > 256) begin failures++; $display("FAIL to_elapsed: got %0d cycles expected 255", cyc); end
        checks++; if (err_mid !== 1'b0) begin failures++; $display("FAIL to_err_early: got %b expected 0", err_mid); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err: got %b expected 1", err); end
        checks++; if (fdc_ack_q !== fq0) begin failures++; $display("FAIL to_fdc_q: got %h expected %h", fdc_ack_q, fq0); end
        tick(5);
        checks++; if (fdc_ack_cnt != a0 + 1) begin failures++; $display("FAIL to_ack_count: got %0d expected 1", fdc_ack_cnt - a0); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL to_sync: got busy=%b expected 1", busy); end
        ack_en = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_clear: got %b expected 0", err); end
        wait_idle(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL to_resync: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int   n0 = log_q.size();
        int   a0;
        int   base;
        bit   ok;
        bit   stable = 1'b1;
        acc_t e;
        ack_en = 1'b0;
        fdc_a = 20'h00030; fdc_we = 1'b0; fdc_req = 1'b1;
        tick(1);
        fdc_req = 1'b0;
        wait_log(n0 + 1, 10, ok);
        tick(3);
        a0 = fdc_ack_cnt;
        reset = 1'b1;
        if (sdram_ack === 1'b0) flip_req++;
        tick(2);
        reset = 1'b0;
        base = log_q.size();
        cpu_ad = 16'h0020; cpu_d = 8'h11; cpu_cs = 1'b1; cpu_we = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (busy !== 1'b1) stable = 1'b0;
        end
        checks++; if (log_q.size() != base) begin failures++; $display("FAIL rst_mid_no_toggle: got %0d toggles expected 0", log_q.size() - base); end
        checks++; if (fdc_ack_cnt != a0) begin failures++; $display("FAIL rst_mid_no_ack: got %0d acks expected 0", fdc_ack_cnt - a0); end
        checks++; if (!stable) begin failures++; $display("FAIL rst_mid_sync: got left SYNC expected held in SYNC"); end
        ack_en = 1'b1;
        wait_log(base + 1, 30, ok);
        e = entry(base);
        checks++; if (!ok || e.a !== 24'h000010 || e.we !== 1'b1) begin failures++; $display("FAIL rst_mid_resume: got a=%h we=%b expected 000010 1", e.a, e.we); end
        cpu_cs = 1'b0; cpu_we = 1'b0;
        wait_idle(50, ok);
        tick(2);
    endtask

    task automatic test_random();
        bit          ok;
        bit          is_fdc;
        bit          is_wr;
        logic [15:0] ad;
        logic [19:0] off;
        logic [7:0]  data;
        logic [7:0]  exp_b;
        logic [23:0] word;
        int          key;
        int          n0;
        int          a0;
        acc_t        e;
        for (int i = 0; i < 60; i++) begin
            lat_max = $urandom_range(3, 0);
            is_fdc = $urandom_range(1, 0);
            is_wr  = $urandom_range(1, 0);
            data   = 8'($urandom);
            if (is_fdc) begin
                off  = ($urandom_range(1, 0) == 1) ? 20'h00100 + 20'($urandom_range(15, 0)) : 20'hFFFF0 + 20'($urandom_range(15, 0));
                word = FDC_BASE + 24'(off >> 1);
                key  = int'(word) * 2 + int'(off[0]);
            end else begin
                ad   = 16'h0400 + 16'($urandom_range(15, 0));
                word = 24'(ad >> 1);
                key  = int'(ad);
            end
            n0 = log_q.size();
            a0 = fdc_ack_cnt;
            if (is_fdc) begin
                fdc_a = off; fdc_we = is_wr; fdc_d = data; fdc_req = 1'b1;
            end else begin
                cpu_ad = ad; cpu_d = data; cpu_cs = 1'b1; cpu_we = is_wr; cpu_oe = !is_wr;
            end
            tick(1);
            fdc_req = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_oe = 1'b0;
            wait_log(n0 + 1, 20, ok);
            e = entry(n0);
            checks++; if (!ok || e.a !== word || e.we !== is_wr) begin failures++; $display("FAIL rnd_cmd_%0d: got a=%h we=%b expected %h %b", i, e.a, e.we, word, is_wr); end
            checks++; if (e.ds !== (is_wr ? ((key % 2 == 1) ? 2'b10 : 2'b01) : 2'b11)) begin failures++; $display("FAIL rnd_ds_%0d: got %b for byte %0d wr %b", i, e.ds, key % 2, is_wr); end
            if (is_wr) begin
                checks++; if (e.d !== {data, data}) begin failures++; $display("FAIL rnd_wdata_%0d: got %h expected %h", i, e.d, {data, data}); end
                ref_mem[key] = data;
            end
            if (is_fdc) begin
                wait_fdc_ack(a0 + 1, 20, ok);
                checks++; if (!ok) begin failures++; $display("FAIL rnd_fdc_ack_%0d: got no ack expected ack", i); end
            end
            wait_idle(20, ok);
            if (!is_wr) begin
                exp_b = ref_mem.exists(key) ? ref_mem[key] : 8'h00;
                if (is_fdc) begin
                    checks++; if (fdc_ack_q !== exp_b) begin failures++; $display("FAIL rnd_fdc_rd_%0d: got %h expected %h", i, fdc_ack_q, exp_b); end
                end else begin
                    checks++; if (cpu_q !== exp_b) begin failures++; $display("FAIL rnd_cpu_rd_%0d: got %h expected %h", i, cpu_q, exp_b); end
                end
            end
        end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rnd_err: got %b expected 0", err); end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_fdc_read();
        test_simultaneous();
        test_streak();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
